display_scan_monitor: RTL and testbench

DISPLAY_SCAN_MONITOR -- requirements
Module: display_scan_monitor

---
 rtl/display_scan_monitor_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/display_scan_monitor.sv | 219 +++++++++++++++++++++
 tb/tb_display_scan_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_monitor_pkg.sv
// display_scan_monitor_pkg
//   Shared definitions for the seven-segment scan monitor:
//   - ANODES_IDLE / SEGS_IDLE : bus values when no digit is being driven
//   - scan_state_e            : capture FSM state encoding
//   - HEX_SEG                 : hex-to-segment table, active-low {g,f,e,d,c,b,a}
//   - onehot_index()          : position of the single set bit in an 8-bit mask
package display_scan_monitor_pkg;

  localparam logic [7:0] ANODES_IDLE = 8'hFF;
  localparam logic [6:0] SEGS_IDLE   = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  // Index = nibble value; entry = active-low cathode pattern {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [2:0] onehot_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational reverse lookup of an active-low segment pattern in HEX_SEG.
//   Ports:
//     seg    [6:0] in  : cathode pattern {g,f,e,d,c,b,a}, active-low
//     nibble [3:0] out : hex value of the matching table entry (0 on miss)
//     hit          out : 1 when seg matches one of the 16 table entries
module seg7_decode
  import display_scan_monitor_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'd0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == HEX_SEG[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_monitor.sv
// display_scan_monitor
//   Watches a multiplexed, active-low seven-segment display bus and recovers
//   the hex value shown on each of the 8 digits. A digit is captured once
//   {an, seg} has been identical for STABLE_CYCLES registered samples.
//
//   Optional feature (macro SCAN_ORDER_CHECK_EN): scan order checking. When
//   defined, every capture after the first must be digit (last+1) mod 8,
//   otherwise err_order is set and the frame mask restarts at the current
//   digit. When undefined, err_order is constant 0.
//
//   Ports:
//     clk, reset           : clock, asynchronous active-high reset
//     an[7:0]              : anode bus, active-low, bit i selects digit i
//     seg[6:0]             : cathode bus {g,f,e,d,c,b,a}, active-low
//     clr_err              : synchronous clear of sticky error flags
//     digits[31:0]         : captured nibbles, digit i at [4i+3:4i]
//     digit_valid[7:0]     : digit i captured since reset
//     frame_done           : one-cycle pulse when digits 0..7 complete a frame
//     err_multi_an         : sticky, more than one anode low in a stable sample
//     err_bad_seg          : sticky, stable pattern not a hex glyph
//     err_order            : sticky, scan order violation
//     dbg_state            : current capture FSM state
//
//   Handshake: there is none; the inputs are free-running sampled buses and
//   every output is a plain registered level (frame_done a single-cycle pulse).
module display_scan_monitor
  import display_scan_monitor_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  input  logic        clr_err,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        err_multi_an,
  output logic        err_bad_seg,
  output logic        err_order,
  output scan_state_e dbg_state
);

  localparam logic [3:0] STABLE_THR = 4'(STABLE_CYCLES);

  // Input stage and the one-cycle-older copy used for change detection.
  logic [7:0] an_q, an_p;
  logic [6:0] seg_q, seg_p;

  scan_state_e state, state_d;
  logic [3:0]  cnt, cnt_d, cnt_inc;
  logic        eval;
  logic        changed;

  logic [7:0]  an_low;
  logic        one_low, multi_low;
  logic [2:0]  cap_idx;
  logic [3:0]  dec_nibble;
  logic        dec_hit;
  logic        capture, bad_ev, multi_ev;
  logic [7:0]  seen, seen_base;
  logic        frame_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= ANODES_IDLE;
      seg_q <= SEGS_IDLE;
      an_p  <= ANODES_IDLE;
      seg_p <= SEGS_IDLE;
    end else begin
      an_q  <= an;
      seg_q <= seg;
      an_p  <= an_q;
      seg_p <= seg_q;
    end
  end

  assign changed = ({an_q, seg_q} != {an_p, seg_p});
  assign cnt_inc = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state. A fresh sample counts as 1; evaluation fires on the cycle
  // the count reaches the threshold, so with a threshold of 1 a new value
  // is evaluated on its first decision cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    eval    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (an_q != ANODES_IDLE) begin
          state_d = ST_SETTLE;
          cnt_d   = 4'd1;
          if (STABLE_THR <= 4'd1) begin
            eval    = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_SETTLE: begin
        if (an_q == ANODES_IDLE) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (changed) begin
          cnt_d = 4'd1;
          if (STABLE_THR <= 4'd1) begin
            eval    = 1'b1;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= STABLE_THR) begin
            eval    = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (an_q == ANODES_IDLE) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (changed) begin
          state_d = ST_SETTLE;
          cnt_d   = 4'd1;
          if (STABLE_THR <= 4'd1) begin
            eval    = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign dbg_state = state;

  // Evaluation of the stable sample
  assign an_low    = ~an_q;
  assign multi_low = ((an_low & (an_low - 8'd1)) != 8'h00);
  assign one_low   = (an_low != 8'h00) && !multi_low;
  assign cap_idx   = onehot_index(an_low);

  seg7_decode u_decode (
    .seg    (seg_q),
    .nibble (dec_nibble),
    .hit    (dec_hit)
  );

  assign capture  = eval && one_low && dec_hit;
  assign bad_ev   = eval && one_low && !dec_hit;
  assign multi_ev = eval && multi_low;

`ifdef SCAN_ORDER_CHECK_EN
  logic       have_last;
  logic [2:0] last_idx;
  logic       order_bad;

  assign order_bad = capture && have_last && (cap_idx != last_idx + 3'd1);
  // An out-of-order capture restarts the frame at the current digit.
  assign seen_base = order_bad ? an_low : (seen | an_low);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_last <= 1'b0;
      last_idx  <= 3'd0;
      err_order <= 1'b0;
    end else begin
      if (capture) begin
        have_last <= 1'b1;
        last_idx  <= cap_idx;
      end
      err_order <= (err_order & ~clr_err) | order_bad;
    end
  end
`else
  assign seen_base = seen | an_low;
  assign err_order = 1'b0;
`endif

  assign frame_hit = capture && (cap_idx == 3'd7) && (seen_base == 8'hFF);

  // Capture, frame tracking and sticky errors. An error event in the same
  // cycle as clr_err leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits       <= 32'h0;
      digit_valid  <= 8'h00;
      seen         <= 8'h00;
      frame_done   <= 1'b0;
      err_multi_an <= 1'b0;
      err_bad_seg  <= 1'b0;
    end else begin
      frame_done <= frame_hit;
      if (capture) begin
        digits[{cap_idx, 2'b00} +: 4] <= dec_nibble;
        digit_valid[cap_idx]          <= 1'b1;
        seen                          <= frame_hit ? 8'h00 : seen_base;
      end
      err_multi_an <= (err_multi_an & ~clr_err) | multi_ev;
      err_bad_seg  <= (err_bad_seg & ~clr_err) | bad_ev;
    end
  end

endmodule

// File: tb/tb_display_scan_monitor.sv
// tb_display_scan_monitor
//   Self-checking bench for display_scan_monitor (STABLE_CYCLES = 4).
//   A reference model of the captured digits is kept in the bench; expected
//   {digit_valid, digits} words are queued when a digit is driven and popped
//   when the hold time has elapsed.
module tb_display_scan_monitor;

`ifdef SCAN_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        clr_err;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        err_multi_an;
  logic        err_bad_seg;
  logic        err_order;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;

  // Reference model
  logic [31:0] model_digits;
  logic [7:0]  model_valid;
  logic [7:0]  model_seen;
  int          exp_frames;
  logic [39:0] exp_q[$];
  logic [39:0] exp_word;

  display_scan_monitor #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .an           (an),
    .seg          (seg),
    .clr_err      (clr_err),
    .digits       (digits),
    .digit_valid  (digit_valid),
    .frame_done   (frame_done),
    .err_multi_an (err_multi_an),
    .err_bad_seg  (err_bad_seg),
    .err_order    (err_order),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) frame_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    an      = 8'hFF;
    seg     = 7'h7F;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_digits = 32'h0;
    model_valid  = 8'h00;
    model_seen   = 8'h00;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Drive a raw bus value at a falling edge and let `cycles` rising edges pass.
  task automatic drive_raw(input logic [7:0] a, input logic [6:0] s, input int cycles);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input int idx, input logic [3:0] val, input int cycles);
    drive_raw(~(8'h01 << idx), glyph(val), cycles);
  endtask

  // Model of one successful capture, including frame completion.
  task automatic model_capture(input int idx, input logic [3:0] val);
    model_digits[idx*4 +: 4] = val;
    model_valid[idx]         = 1'b1;
    model_seen[idx]          = 1'b1;
    if (idx == 7 && model_seen == 8'hFF) begin
      exp_frames++;
      model_seen = 8'h00;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (digits !== 32'h0) begin errors++; $display("FAIL reset_digits got %h want %h", digits, 32'h0); end
    checks++; if (digit_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h want %h", digit_valid, 8'h00); end
    checks++; if ({frame_done, err_multi_an, err_bad_seg, err_order} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags got %b want 0000", {frame_done, err_multi_an, err_bad_seg, err_order}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
  endtask

  // Digit 0 shows "0": nothing after 4 edges, captured at edge 5.
  task automatic test_latency();
    @(negedge clk);
    an  = 8'hFE;
    seg = 7'h40;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (digit_valid !== 8'h00) begin errors++; $display("FAIL latency_early got %h want %h", digit_valid, 8'h00); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL latency_settle got %0d want 1", dbg_state); end
    @(posedge clk);
    #1;
    model_capture(0, 4'h0);
    checks++; if (digit_valid !== 8'h01) begin errors++; $display("FAIL latency_valid got %h want %h", digit_valid, 8'h01); end
    checks++; if (digits[3:0] !== 4'h0) begin errors++; $display("FAIL latency_digit got %h want 0", digits[3:0]); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL latency_hold got %0d want 2", dbg_state); end
    @(posedge clk);
    #1;
    checks++; if (digit_valid !== 8'h01) begin errors++; $display("FAIL latency_keep got %h want %h", digit_valid, 8'h01); end
  endtask

  task automatic test_frame();
    int f0;
    f0 = frame_cnt;
    exp_frames = 0;
    for (int i = 0; i < 8; i++) begin
      model_capture(i, 4'(i + 1));
      exp_q.push_back({model_valid, model_digits});
      drive_digit(i, 4'(i + 1), 10);
      exp_word = exp_q.pop_front();
      checks++; if ({digit_valid, digits} !== exp_word) begin errors++;
        $display("FAIL frame_step%0d got %h want %h", i, {digit_valid, digits}, exp_word); end
      checks++; if (frame_cnt - f0 !== exp_frames) begin errors++;
        $display("FAIL frame_pulse%0d got %0d want %0d", i, frame_cnt - f0, exp_frames); end
    end
    checks++; if (digits !== 32'h87654321) begin errors++; $display("FAIL frame_digits got %h want %h", digits, 32'h87654321); end
    checks++; if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL frame_count got %0d want 1", frame_cnt - f0); end
  endtask

  task automatic test_multi_an();
    exp_q.push_back({model_valid, model_digits});
    drive_raw(8'hFC, glyph(4'h1), 10);
    exp_word = exp_q.pop_front();
    checks++; if (err_multi_an !== 1'b1) begin errors++; $display("FAIL multi_set got %b want 1", err_multi_an); end
    checks++; if ({digit_valid, digits} !== exp_word) begin errors++;
      $display("FAIL multi_digits got %h want %h", {digit_valid, digits}, exp_word); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    #1;
    checks++; if (err_multi_an !== 1'b0) begin errors++; $display("FAIL multi_clear got %b want 0", err_multi_an); end
    // clr_err held through a new multi-anode evaluation: the set wins.
    @(negedge clk);
    seg     = glyph(4'h2);
    clr_err = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (err_multi_an !== 1'b0) begin errors++; $display("FAIL multi_pre got %b want 0", err_multi_an); end
    @(posedge clk);
    #1;
    checks++; if (err_multi_an !== 1'b1) begin errors++; $display("FAIL multi_set_wins got %b want 1", err_multi_an); end
    @(negedge clk); clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_multi_an !== 1'b1) begin errors++; $display("FAIL multi_sticky got %b want 1", err_multi_an); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  // Only segment a lit: not one of the 16 hex glyphs.
  task automatic test_bad_seg();
    exp_q.push_back({model_valid, model_digits});
    drive_raw(8'hFB, 7'h7E, 10);
    exp_word = exp_q.pop_front();
    checks++; if (err_bad_seg !== 1'b1) begin errors++; $display("FAIL badseg_set got %b want 1", err_bad_seg); end
    checks++; if (err_multi_an !== 1'b0) begin errors++; $display("FAIL badseg_multi got %b want 0", err_multi_an); end
    checks++; if ({digit_valid, digits} !== exp_word) begin errors++;
      $display("FAIL badseg_digits got %h want %h", {digit_valid, digits}, exp_word); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    #1;
    checks++; if (err_bad_seg !== 1'b0) begin errors++; $display("FAIL badseg_clear got %b want 0", err_bad_seg); end
  endtask

  task automatic test_unstable_and_reset();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive_raw(8'hF7, glyph((k % 2 == 0) ? 4'h5 : 4'h6), 2);
      checks++; if (digit_valid !== 8'h00) begin errors++; $display("FAIL toggle%0d got %h want %h", k, digit_valid, 8'h00); end
    end
    drive_digit(3, 4'h9, 8);
    checks++; if (digit_valid !== 8'h08 || digits !== 32'h00009000) begin errors++;
      $display("FAIL toggle_then_stable got %h/%h want 08/00009000", digit_valid, digits); end
    // New value, then async reset in the middle of SETTLE.
    @(negedge clk);
    seg = glyph(4'h4);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL mid_settle got %0d want 1", dbg_state); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({digit_valid, digits} !== 40'h0 || dbg_state !== 2'd0) begin errors++;
      $display("FAIL async_reset got %h state %0d want 0 state 0", {digit_valid, digits}, dbg_state); end
    checks++; if ({frame_done, err_multi_an, err_bad_seg, err_order} !== 4'b0000) begin errors++;
      $display("FAIL async_reset_flags got %b want 0000", {frame_done, err_multi_an, err_bad_seg, err_order}); end
    an  = 8'hFF;
    seg = 7'h7F;
    @(negedge clk);
    reset = 1'b0;
    model_digits = 32'h0;
    model_valid  = 8'h00;
    model_seen   = 8'h00;
  endtask

  // Sequential scan with random values, hold times and blank gaps.
  task automatic test_random_scan();
    int f0;
    logic [3:0] v;
    int gap;
    int hold;
    f0 = frame_cnt;
    exp_frames = 0;
    for (int k = 0; k < 16; k++) begin
      v    = 4'($urandom_range(0, 15));
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(5, 9);
      if (gap > 0) drive_raw(8'hFF, 7'h7F, gap);
      model_capture(k % 8, v);
      exp_q.push_back({model_valid, model_digits});
      drive_digit(k % 8, v, hold);
      exp_word = exp_q.pop_front();
      checks++; if ({digit_valid, digits} !== exp_word) begin errors++;
        $display("FAIL random%0d got %h want %h", k, {digit_valid, digits}, exp_word); end
    end
    drive_raw(8'hFF, 7'h7F, 2);
    checks++; if (frame_cnt - f0 !== exp_frames) begin errors++;
      $display("FAIL random_frames got %0d want %0d", frame_cnt - f0, exp_frames); end
  endtask

  task automatic test_order();
    do_reset();
    drive_digit(0, 4'hA, 8);
    drive_digit(1, 4'hB, 8);
    checks++; if (err_order !== 1'b0) begin errors++; $display("FAIL order_inseq got %b want 0", err_order); end
    drive_digit(3, 4'hC, 8);
    checks++; if (err_order !== ORDER_EN) begin errors++; $display("FAIL order_skip got %b want %b", err_order, ORDER_EN); end
    checks++; if (digits !== 32'h0000C0BA || digit_valid !== 8'h0B) begin errors++;
      $display("FAIL order_digits got %h/%h want 0000c0ba/0b", digits, digit_valid); end
  endtask

  initial begin
    reset   = 1'b1;
    an      = 8'hFF;
    seg     = 7'h7F;
    clr_err = 1'b0;
    model_digits = 32'h0;
    model_valid  = 8'h00;
    model_seen   = 8'h00;
    exp_frames   = 0;
    test_reset();
    test_latency();
    test_frame();
    test_multi_an();
    test_bad_seg();
    test_unstable_and_reset();
    test_random_scan();
    test_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
